// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle datapath controller.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
//
// Contents: opcode width and values, FSM state encoding, pc_src / alu_op codes.
package multicycle_controller_pkg;

    localparam int MC_OPCODE_WIDTH = 4;

    // Opcode values carried in the top bits of the instruction word.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FADDR = 3'd0,
        S_FWAIT = 3'd1,
        S_DEC   = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    // PC next-value select.
    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_PASS_B = 2'b10;

    // Opcodes that continue from decode into the execute state.
    function automatic logic op_needs_exec(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)  || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Memory wait timer: counts mem_ready-low cycles while the controller waits on memory.
// Latency: o_expired is combinational in the cycle the count reaches MEM_TIMEOUT.
// Backpressure: none; observes mem_ready only.
//
// Compiled only with MULTICYCLE_CTRL_MEM_TIMEOUT_EN defined (the feature it implements).
// Ports: i_clk, i_reset (sync, active-high), i_waiting (controller in a memory wait
// state), i_mem_ready, o_expired (wait exhausted, mem_ready still low).
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
module multicycle_controller_mem_wait_timer #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_waiting,
    input  logic i_mem_ready,
    output logic o_expired
);

    logic [7:0] r_count;

    // Held at zero outside the wait states, so every entry into a wait starts at 0.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_waiting) begin
            r_count <= 8'd0;
        end else if (!i_mem_ready && (r_count != MEM_TIMEOUT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_waiting & ~i_mem_ready & (r_count == MEM_TIMEOUT);

endmodule
`endif

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle datapath.
// Latency: JMP 3, BEQ 4, ADD/ADDI/SW 5, LW 6 cycles, +1 per mem_ready-low cycle.
// Backpressure: mem_req held until mem_ready; the FSM stalls in the wait state meanwhile.
//
// Ports: i_clk, i_reset (sync, active-high), i_opcode (from IR), i_alu_zero, i_mem_ready;
// o_* datapath enables/selects, o_mem_req/o_mem_we, o_halted, o_bus_error.
// Optional feature: define MULTICYCLE_CTRL_MEM_TIMEOUT_EN to halt with a sticky bus_error
// when a memory wait exceeds MEM_TIMEOUT cycles; otherwise waits forever, bus_error = 0.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int OPCODE_WIDTH = MC_OPCODE_WIDTH
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    ,
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_alu_zero,
    input  logic                    i_mem_ready,
    output logic                    o_ir_write,
    output logic                    o_mar_write,
    output logic                    o_mar_src,
    output logic                    o_mdr_write,
    output logic                    o_ab_write,
    output logic                    o_pc_write,
    output logic [1:0]              o_pc_src,
    output logic [1:0]              o_alu_op,
    output logic                    o_alu_src_b,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic                    o_reg_write,
    output logic                    o_wb_src,
    output logic                    o_halted,
    output logic                    o_bus_error
);

    state_t r_state;
    state_t w_next;

    logic       w_timeout;
    logic       w_bus_error;
    logic [3:0] w_op;

    logic       w_ir_write, w_mar_write, w_mar_src, w_mdr_write, w_ab_write;
    logic       w_pc_write, w_alu_src_b, w_mem_req, w_mem_we, w_reg_write;
    logic       w_wb_src, w_halted;
    logic [1:0] w_pc_src, w_alu_op;

    // Opcode constants are 4 bits; an all-ones opcode of any width still decodes as HALT.
    assign w_op = (i_opcode == {OPCODE_WIDTH{1'b1}}) ? OP_HALT : 4'(i_opcode);

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    logic r_bus_error;

    multicycle_controller_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_waiting   ((r_state == S_FWAIT) || (r_state == S_MEM)),
        .i_mem_ready (i_mem_ready),
        .o_expired   (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bus_error <= 1'b0;
        end else if (w_timeout) begin
            r_bus_error <= 1'b1;
        end
    end

    assign w_bus_error = r_bus_error;
`else
    assign w_timeout   = 1'b0;
    assign w_bus_error = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FADDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ir_write  = 1'b0;
        w_mar_write = 1'b0;
        w_mar_src   = 1'b0;
        w_mdr_write = 1'b0;
        w_ab_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = PC_SRC_INC;
        w_alu_op    = ALU_ADD;
        w_alu_src_b = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_reg_write = 1'b0;
        w_wb_src    = 1'b0;
        w_halted    = 1'b0;

        case (r_state)
            S_FADDR: begin
                w_mar_write = 1'b1;
                w_next      = S_FWAIT;
            end

            S_FWAIT: begin
                w_mem_req = 1'b1;
                if (w_timeout) begin
                    w_next = S_HALT;
                end else if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DEC;
                end
            end

            S_DEC: begin
                w_ab_write = 1'b1;
                if (op_needs_exec(w_op)) begin
                    w_next = S_EXEC;
                end else if (w_op == OP_JMP) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_SRC_JUMP;
                    w_next     = S_FADDR;
                end else if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_FADDR;
                end
            end

            S_EXEC: begin
                w_next = S_FADDR;
                case (w_op)
                    OP_ADD:  w_next = S_WB;
                    OP_ADDI: begin
                        w_alu_src_b = 1'b1;
                        w_next      = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        w_alu_src_b = 1'b1;
                        w_mar_write = 1'b1;
                        w_mar_src   = 1'b1;
                        w_next      = S_MEM;
                    end
                    OP_BEQ: begin
                        w_alu_op   = ALU_SUB;
                        w_pc_write = i_alu_zero;
                        w_pc_src   = PC_SRC_BRANCH;
                    end
                    default: w_next = S_FADDR;
                endcase
            end

            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_op == OP_SW);
                if (w_timeout) begin
                    w_next = S_HALT;
                end else if (i_mem_ready) begin
                    if (w_op == OP_LW) begin
                        w_mdr_write = 1'b1;
                        w_next      = S_WB;
                    end else begin
                        w_next = S_FADDR;
                    end
                end
            end

            S_WB: begin
                w_reg_write = 1'b1;
                w_wb_src    = (w_op == OP_LW);
                w_next      = S_FADDR;
            end

            S_HALT: begin
                w_halted = 1'b1;
            end

            default: w_next = S_FADDR;
        endcase
    end

    // While reset is asserted every output is forced low, so a wait in progress
    // drops mem_req immediately and the abandoned transaction is never completed.
    assign o_ir_write  = ~i_reset & w_ir_write;
    assign o_mar_write = ~i_reset & w_mar_write;
    assign o_mar_src   = ~i_reset & w_mar_src;
    assign o_mdr_write = ~i_reset & w_mdr_write;
    assign o_ab_write  = ~i_reset & w_ab_write;
    assign o_pc_write  = ~i_reset & w_pc_write;
    assign o_pc_src    = {2{~i_reset}} & w_pc_src;
    assign o_alu_op    = {2{~i_reset}} & w_alu_op;
    assign o_alu_src_b = ~i_reset & w_alu_src_b;
    assign o_mem_req   = ~i_reset & w_mem_req;
    assign o_mem_we    = ~i_reset & w_mem_we;
    assign o_reg_write = ~i_reset & w_reg_write;
    assign o_wb_src    = ~i_reset & w_wb_src;
    assign o_halted    = ~i_reset & w_halted;
    assign o_bus_error = ~i_reset & w_bus_error;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected output vectors are
// built from the instruction sequence, queued as each cycle's stimulus is driven and
// compared when the outputs are sampled on the falling edge.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic ir_write, mar_write, mar_src, mdr_write, ab_write, pc_write;
    logic [1:0] pc_src, alu_op;
    logic alu_src_b, mem_req, mem_we, reg_write, wb_src, halted, bus_error;

    always #5 clk = ~clk;

    multicycle_controller #(
        .OPCODE_WIDTH (4)
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
        ,
        .MEM_TIMEOUT  (8'd4)
`endif
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_opcode    (opcode),
        .i_alu_zero  (alu_zero),
        .i_mem_ready (mem_ready),
        .o_ir_write  (ir_write),
        .o_mar_write (mar_write),
        .o_mar_src   (mar_src),
        .o_mdr_write (mdr_write),
        .o_ab_write  (ab_write),
        .o_pc_write  (pc_write),
        .o_pc_src    (pc_src),
        .o_alu_op    (alu_op),
        .o_alu_src_b (alu_src_b),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_reg_write (reg_write),
        .o_wb_src    (wb_src),
        .o_halted    (halted),
        .o_bus_error (bus_error)
    );

    wire [16:0] obs = {ir_write, mar_write, mar_src, mdr_write, ab_write, pc_write, pc_src,
                       alu_op, alu_src_b, mem_req, mem_we, reg_write, wb_src, halted, bus_error};

    typedef struct {
        logic [3:0]  op;
        logic        rdy;
        logic        zero;
        logic [16:0] exp;
        string       tag;
    } step_t;

    step_t       stim_q[$];
    logic [16:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [16:0] mk(input logic ir, mar, msrc, mdr, ab, pcw,
                                       input logic [1:0] pcs, aop,
                                       input logic srcb, req, we, rw, wb, hlt, be);
        return {ir, mar, msrc, mdr, ab, pcw, pcs, aop, srcb, req, we, rw, wb, hlt, be};
    endfunction

    task automatic push(input logic [3:0] op, input logic rdy, input logic zero,
                        input logic [16:0] exp, input string tag);
        step_t s;
        s.op = op; s.rdy = rdy; s.zero = zero; s.exp = exp; s.tag = tag;
        stim_q.push_back(s);
    endtask

    // Reference sequence of one instruction, written from the state descriptions.
    task automatic add_instr(input logic [3:0] op, input int fw_lows, input int mem_lows,
                             input logic zero);
        push(op, 1'b0, 1'b0, mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), "faddr");
        for (int i = 0; i < fw_lows; i++)
            push(op, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,1,0,0,0,0,0), "fwait");
        push(op, 1'b1, 1'b0, mk(1,0,0,0,0,1,2'b00,2'b00,0,1,0,0,0,0,0), "fetch");
        if (op == 4'h5) begin
            push(op, 1'b1, 1'b0, mk(0,0,0,0,1,1,2'b10,2'b00,0,0,0,0,0,0,0), "dec_jmp");
            return;
        end
        push(op, 1'b1, 1'b0, mk(0,0,0,0,1,0,2'b00,2'b00,0,0,0,0,0,0,0), "dec");
        if (op > 4'h4) return;
        case (op)
            4'h0: push(op, 1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), "exec_add");
            4'h1: push(op, 1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,1,0,0,0,0,0,0), "exec_addi");
            4'h4: push(op, 1'b1, zero, mk(0,0,0,0,0,zero,2'b01,2'b01,0,0,0,0,0,0,0), "exec_beq");
            default: push(op, 1'b1, 1'b0, mk(0,1,1,0,0,0,2'b00,2'b00,1,0,0,0,0,0,0), "exec_mem");
        endcase
        if (op == 4'h2 || op == 4'h3) begin
            for (int i = 0; i < mem_lows; i++)
                push(op, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,1,op[0],0,0,0,0), "mem_wait");
            push(op, 1'b1, 1'b0, mk(0,0,0,op==4'h2,0,0,2'b00,2'b00,0,1,op[0],0,0,0,0), "mem_done");
        end
        if (op != 4'h3 && op != 4'h4)
            push(op, 1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0,1,op==4'h2,0,0), "wb");
    endtask

    // Drive each queued step, queue its expectation, compare on the falling edge.
    task automatic run_steps();
        step_t s;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode    = s.op;
            mem_ready = s.rdy;
            alu_zero  = s.zero;
            exp_q.push_back(s.exp);
            tag_q.push_back(s.tag);
            @(negedge clk);
            check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check(tag, 32'(obs), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops[8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hC};

        do_reset("reset_outputs");

        // Directed instruction stream, ending with a refetch to confirm the NOP returns.
        add_instr(4'h0, 0, 0, 1'b0);
        add_instr(4'h1, 0, 0, 1'b0);
        add_instr(4'h2, 0, 3, 1'b0);
        add_instr(4'h3, 1, 0, 1'b0);
        add_instr(4'h4, 0, 0, 1'b1);
        add_instr(4'h4, 0, 0, 1'b0);
        add_instr(4'h5, 0, 0, 1'b0);
        add_instr(4'h9, 0, 0, 1'b0);
        push(4'h0, 1'b0, 1'b0, mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), "faddr_after_nop");
        run_steps();

        do_reset("reset_between");
        for (int i = 0; i < 24; i++)
            add_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)));
        run_steps();

        // Reset while waiting on the fetch: mem_req drops and the FSM restarts at fetch.
        do_reset("reset_pre_wait");
        push(4'h0, 1'b0, 1'b0, mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), "faddr");
        push(4'h0, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,1,0,0,0,0,0), "fwait_req");
        run_steps();
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_wait", 32'(obs), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_faddr", 32'(obs),
              32'(mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0)));

        // HALT holds for 20 cycles with no enables.
        do_reset("reset_pre_halt");
        add_instr(4'hF, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++)
            push(4'hF, 1'($urandom_range(0, 1)), 1'b0,
                 mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0,0,0,1,0), "halt_hold");
        run_steps();

        // Memory never answers the fetch.
        do_reset("reset_pre_timeout");
        push(4'h0, 1'b0, 1'b0, mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), "faddr");
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < 5; i++)
            push(4'h0, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,1,0,0,0,0,0), "fwait_timer");
        for (int i = 0; i < 4; i++)
            push(4'h0, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0,0,0,1,1), "timeout_halt");
`else
        for (int i = 0; i < 300; i++)
            push(4'h0, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,1,0,0,0,0,0), "fwait_forever");
`endif
        run_steps();
        do_reset("reset_clears_error");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
